// File: rtl/zsig_pkg.sv
// zsig_pkg: shared constants and helpers for the zsig_delay signal-delay block.
//   - default channel count and rise/fall delays
//   - per-channel state encoding (IDLE / PEND)
//   - cnt_width(): counter width needed to count up to max(rise, fall) - 1
package zsig_pkg;

  localparam int DEF_CHANNELS = 6;
  localparam int DEF_RISE_DLY = 3;
  localparam int DEF_FALL_DLY = 2;

  typedef enum logic {
    IDLE = 1'b0,  // sample equals output, counter parked at 0
    PEND = 1'b1   // sample differs from output, counting toward expiry
  } ch_state_e;

  function automatic int cnt_width(input int rise, input int fall);
    return $clog2((rise > fall) ? rise : fall) + 1;
  endfunction

endpackage

// File: rtl/zsig_delay_if.sv
// zsig_delay_if: bundles the channel bus of zsig_delay.
//   din    : raw control signals (CHANNELS)
//   smask  : 1 = channel sampled on strobe cycles only
//   strobe : sample enable for masked channels
//   dout   : delayed, deglitched signals
//   busy   : any channel has a pending transition
// master drives din/smask/strobe; slave (the delay block) drives dout/busy.
interface zsig_delay_if #(
  parameter int CHANNELS = 6
);
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] smask;
  logic                strobe;
  logic [CHANNELS-1:0] dout;
  logic                busy;

  modport master (output din, smask, strobe, input  dout, busy);
  modport slave  (input  din, smask, strobe, output dout, busy);
endinterface

// File: rtl/zsig_delay_ch.sv
// zsig_delay_ch: one inertial-delay channel.
//   fclk, rst : clock, async active-high reset
//   din       : raw input bit
//   smask     : 1 = load sample only when strobe is high
//   strobe    : sample enable for masked operation
//   dout      : delayed output bit (registered)
//   pend      : sample differs from output (transition pending)
//   cancel    : this cycle a pending transition is swallowed
// A new sample value must persist for RISE_DLY (0->1) or FALL_DLY (1->0)
// edges before it reaches dout; returning early cancels the transition.
module zsig_delay_ch
  import zsig_pkg::*;
#(
  parameter int   RISE_DLY = DEF_RISE_DLY,
  parameter int   FALL_DLY = DEF_FALL_DLY,
  parameter logic RST_BIT  = 1'b1,
  parameter int   CW       = cnt_width(RISE_DLY, FALL_DLY)
) (
  input  logic fclk,
  input  logic rst,
  input  logic din,
  input  logic smask,
  input  logic strobe,
  output logic dout,
  output logic pend,
  output logic cancel
);

  localparam logic [CW-1:0] RISE_C = CW'(RISE_DLY);
  localparam logic [CW-1:0] FALL_C = CW'(FALL_DLY);

  logic          s;
  logic [CW-1:0] cnt, cnt_n;
  logic          dout_n;
  ch_state_e     state, state_n;
  logic [CW-1:0] d_sel;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      s     <= RST_BIT;
      dout  <= RST_BIT;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      if (!smask || strobe) s <= din;
      dout  <= dout_n;
      cnt   <= cnt_n;
      state <= state_n;
    end
  end

  // Delay depends on the direction of the pending transition, i.e. on s.
  assign d_sel = s ? RISE_C : FALL_C;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
    cancel  = 1'b0;
    case (state)
      IDLE: begin
        if (s != dout) begin
          if (cnt == d_sel - 1'b1) begin
            dout_n  = s;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n   = cnt + 1'b1;
            state_n = PEND;
          end
        end
      end
      PEND: begin
        if (s == dout) begin
          // Sample fell back before expiry: swallow the pulse.
          cnt_n   = '0;
          state_n = IDLE;
          cancel  = 1'b1;
        end else if (cnt == d_sel - 1'b1) begin
          dout_n  = s;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n   = cnt + 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign pend = (s != dout);

endmodule

// File: rtl/zsig_delay.sv
// zsig_delay: multi-channel inertial delay / deglitcher for control strobes.
//   fclk       : system clock, rising edge
//   rst        : async active-high reset
//   bus        : zsig_delay_if.slave (din, smask, strobe in; dout, busy out)
//   glitch_clr : (ZSIG_GLITCH_CNT_EN only) clear glitch counter, wins over increment
//   glitch_cnt : (ZSIG_GLITCH_CNT_EN only) saturating count of cycles with a cancel
// Optional feature macro: ZSIG_GLITCH_CNT_EN.
module zsig_delay
  import zsig_pkg::*;
#(
  parameter int                  CHANNELS = DEF_CHANNELS,
  parameter int                  RISE_DLY = DEF_RISE_DLY,
  parameter int                  FALL_DLY = DEF_FALL_DLY,
  parameter logic [CHANNELS-1:0] RST_VAL  = '1
) (
  input  logic         fclk,
  input  logic         rst,
  zsig_delay_if.slave  bus
`ifdef ZSIG_GLITCH_CNT_EN
  ,
  input  logic         glitch_clr,
  output logic [15:0]  glitch_cnt
`endif
);

  localparam int CW = cnt_width(RISE_DLY, FALL_DLY);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] cancel;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    zsig_delay_ch #(
      .RISE_DLY (RISE_DLY),
      .FALL_DLY (FALL_DLY),
      .RST_BIT  (RST_VAL[i]),
      .CW       (CW)
    ) u_ch (
      .fclk   (fclk),
      .rst    (rst),
      .din    (bus.din[i]),
      .smask  (bus.smask[i]),
      .strobe (bus.strobe),
      .dout   (bus.dout[i]),
      .pend   (pend[i]),
      .cancel (cancel[i])
    );
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) bus.busy <= 1'b0;
    else     bus.busy <= |pend;
  end

`ifdef ZSIG_GLITCH_CNT_EN
  always_ff @(posedge fclk or posedge rst) begin
    if (rst)                                        glitch_cnt <= '0;
    else if (glitch_clr)                            glitch_cnt <= '0;
    else if ((|cancel) && (glitch_cnt != 16'hFFFF)) glitch_cnt <= glitch_cnt + 16'd1;
  end
`else
  // Cancel flags only feed the optional glitch counter.
  logic unused_cancel;
  assign unused_cancel = |cancel;
`endif

endmodule

// File: tb/tb_zsig_delay.sv
// tb_zsig_delay: directed checks of zsig_delay with CHANNELS=6, RISE_DLY=3,
// FALL_DLY=2, RST_VAL=6'h3F. Inputs change 1 time unit after a rising edge
// and outputs are sampled at the same point, so "tick" = one edge elapsed.
module tb_zsig_delay;

  logic fclk = 1'b0;
  logic rst;
  logic glitch_clr;
  logic [15:0] glitch_cnt;
  int total = 0;
  int bad   = 0;

  zsig_delay_if #(.CHANNELS(6)) bus ();

  zsig_delay #(
    .CHANNELS (6),
    .RISE_DLY (3),
    .FALL_DLY (2),
    .RST_VAL  (6'h3F)
  ) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
`ifdef ZSIG_GLITCH_CNT_EN
    ,
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt)
`endif
  );

`ifndef ZSIG_GLITCH_CNT_EN
  assign glitch_cnt = 16'h0;
`endif

  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] d, input logic b);
    chk({tag, ".dout"}, {26'd0, bus.dout}, {26'd0, d});
    chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, b});
  endtask

  initial begin
    rst        = 1'b1;
    glitch_clr = 1'b0;
    bus.din    = 6'h3F;
    bus.smask  = 6'h00;
    bus.strobe = 1'b0;
    #1;
    chk_out("rst", 6'h3F, 1'b0);
    tick();
    tick();
    rst = 1'b0;
`ifdef ZSIG_GLITCH_CNT_EN
    chk("rst.glitch", {16'd0, glitch_cnt}, 32'd0);
`endif

    // Idle after reset: steady high input, nothing moves.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("idle", 6'h3F, 1'b0);
    end

    // ch0 fall (2 edges) then rise (3 edges).
    bus.din[0] = 1'b0;
    tick(); chk_out("fall0.k",   6'h3F, 1'b0);
    tick(); chk_out("fall0.k1",  6'h3F, 1'b1);
    tick(); chk_out("fall0.k2",  6'h3E, 1'b1);
    tick(); chk_out("fall0.k3",  6'h3E, 1'b0);
    bus.din[0] = 1'b1;
    tick(); chk_out("rise0.m",   6'h3E, 1'b0);
    tick(); chk_out("rise0.m1",  6'h3E, 1'b1);
    tick(); chk_out("rise0.m2",  6'h3E, 1'b1);
    tick(); chk_out("rise0.m3",  6'h3F, 1'b1);
    tick(); chk_out("rise0.m4",  6'h3F, 1'b0);

    // ch2 one-cycle low glitch is swallowed.
    bus.din[2] = 1'b0;
    tick(); chk_out("gl2.k",  6'h3F, 1'b0);
    bus.din[2] = 1'b1;
    tick(); chk_out("gl2.k1", 6'h3F, 1'b1);
    tick(); chk_out("gl2.k2", 6'h3F, 1'b0);
`ifdef ZSIG_GLITCH_CNT_EN
    chk("gl2.cnt", {16'd0, glitch_cnt}, 32'd1);
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    chk("gl2.clr", {16'd0, glitch_cnt}, 32'd0);
    // Clear on the same edge as a cancel wins.
    bus.din[2] = 1'b0;
    tick();
    bus.din[2] = 1'b1;
    tick();
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    chk("gl2.clrprio", {16'd0, glitch_cnt}, 32'd0);
    // Two channels cancelling on the same edge count once.
    bus.din[4:3] = 2'b00;
    tick();
    bus.din[4:3] = 2'b11;
    tick();
    tick();
    chk("gl34.cnt", {16'd0, glitch_cnt}, 32'd1);
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
`endif
    chk_out("gl.settle", 6'h3F, 1'b0);

    // ch1 low for exactly FALL_DLY cycles: appears, then rises 3 edges after.
    bus.din[1] = 1'b0;
    tick();
    tick(); chk_out("p1.k1", 6'h3F, 1'b1);
    bus.din[1] = 1'b1;
    tick(); chk_out("p1.k2", 6'h3D, 1'b1);
    tick();
    tick(); chk_out("p1.k4", 6'h3D, 1'b1);
    tick(); chk_out("p1.k5", 6'h3F, 1'b1);
    tick(); chk_out("p1.k6", 6'h3F, 1'b0);
`ifdef ZSIG_GLITCH_CNT_EN
    chk("p1.cnt", {16'd0, glitch_cnt}, 32'd0);
`endif

    // ch5 masked: change held off until a strobe loads it.
    bus.smask  = 6'h20;
    bus.din[5] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("m5.wait", 6'h3F, 1'b0);
    end
    bus.strobe = 1'b1;
    tick();
    bus.strobe = 1'b0;
    chk_out("m5.j",  6'h3F, 1'b0);
    tick(); chk_out("m5.j1", 6'h3F, 1'b1);
    tick(); chk_out("m5.j2", 6'h1F, 1'b1);
    bus.smask  = 6'h00;
    bus.din[5] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_out("m5.back", 6'h3F, 1'b0);

    // All channels fall on the same edge, then all rise together.
    bus.din = 6'h00;
    tick(); chk_out("all.k",  6'h3F, 1'b0);
    tick(); chk_out("all.k1", 6'h3F, 1'b1);
    tick(); chk_out("all.k2", 6'h00, 1'b1);
    bus.din = 6'h3F;
    tick();
    tick();
    tick(); chk_out("all.m2", 6'h00, 1'b1);
    tick(); chk_out("all.m3", 6'h3F, 1'b1);
    tick(); chk_out("all.m4", 6'h3F, 1'b0);

    // Reset asserted mid-count discards the pending fall.
    bus.din = 6'h00;
    tick();
    tick(); chk_out("rmid.k1", 6'h3F, 1'b1);
    #2 rst = 1'b1;
    #1 chk_out("rmid.async", 6'h3F, 1'b0);
    bus.din = 6'h3F;
    tick(); chk_out("rmid.hold", 6'h3F, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("rmid.after", 6'h3F, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zsig_delay.md
ZSIG_DELAY -- requirements
Module: zsig_delay

Interface
- REQ-001: Parameter CHANNELS, default 6, sets the number of independent control-signal channels (1..32).
- REQ-002: Parameter RISE_DLY, default 3, sets the rising-transition (0->1) delay in fclk cycles (1..255).
- REQ-003: Parameter FALL_DLY, default 2, sets the falling-transition (1->0) delay in fclk cycles (1..255).
- REQ-004: Parameter RST_VAL, default all ones, sets the per-channel reset value of dout (active-low bus signals idle high).
- REQ-005: fclk  input  1  system clock; all state updates on its rising edge.
- REQ-006: rst  input  1  reset; one clock, reset asynchronous and active-high.
- REQ-007: din  input  CHANNELS  raw signals (e.g. m1_n, rfsh_n, mreq_n, iorq_n, rd_n, wr_n).
- REQ-008: smask  input  CHANNELS  1 = channel sampled only on strobe cycles; 0 = sampled every cycle.
- REQ-009: strobe  input  1  sample-enable pulse for masked channels (e.g. Z80 clock falling phase).
- REQ-010: dout  output  CHANNELS  delayed, deglitched signals, registered.
- REQ-011: busy  output  1  OR of all channels' pending flags, registered.

Function
- REQ-012: Each channel holds sample register s; s <= din[i] every cycle when smask[i]=0, only on cycles with strobe=1 when smask[i]=1.
- REQ-013: Each channel has states IDLE (s==dout, cnt=0) and PEND (s!=dout, counting).
- REQ-014: In PEND, D = RISE_DLY if s=1, else FALL_DLY; if cnt==D-1 then dout<=s, cnt<=0, else cnt<=cnt+1.
- REQ-015: Latency: dout changes on the D-th rising edge after the edge that loaded the new value into s.
- REQ-016: Inertial behaviour: if s returns to dout before expiry, cnt<=0 and the channel returns to IDLE with dout unchanged (pulse swallowed).
- REQ-017: A pulse on din shorter than D cycles never appears on dout; a pulse of at least D cycles appears with its width preserved when RISE_DLY==FALL_DLY.
- REQ-018: Counter width = clog2(max(RISE_DLY,FALL_DLY))+1; cnt never exceeds D-1.
- REQ-019: Channels are fully independent; simultaneous transitions on several channels each follow REQ-014.
- REQ-020: A smask change takes effect on the next cycle; a pending count continues from its current value.
- REQ-021: busy = 1 on the cycle after any channel enters PEND, and 0 on the cycle after all channels are IDLE.

Reset
- REQ-022: While rst=1: dout=RST_VAL, s=RST_VAL, every cnt=0, busy=0, glitch_cnt=0; reset asserted mid-count discards the pending transition.
- REQ-023: After rst deasserts, the first sample is taken on the first rising edge.

Configuration
- REQ-024: Macro ZSIG_GLITCH_CNT_EN defined: adds inputs/outputs glitch_clr (input, 1) and glitch_cnt (output, 16); glitch_cnt increments once per cycle in which at least one channel cancels (REQ-016), saturates at 0xFFFF, and glitch_clr=1 zeroes it, taking priority over a same-cycle increment.
- REQ-025: Macro undefined: the ports are absent and no counter logic exists; dout/busy behaviour is identical.

Structure
- REQ-026: Package zsig_pkg holds the default delay constants, the state encoding (IDLE/PEND) and the counter-width function.
- REQ-027: Sub-module zsig_delay_ch implements one channel (s, cnt, state, dout bit, cancel flag); the top generates CHANNELS instances, busy and the optional glitch counter.

Verification (CHANNELS=6, RISE_DLY=3, FALL_DLY=2, RST_VAL=6'h3F)
- REQ-028: Reset release, din=6'h3F steady -> dout=6'h3F, busy=0 indefinitely.
- REQ-029: din[0] 1->0 loaded at edge k -> dout[0]=0 at edge k+2; back to 1 loaded at edge m -> dout[0]=1 at edge m+3; busy=1 throughout the intervals.
- REQ-030: din[2] low for 1 cycle -> dout[2] stays 1; glitch_cnt 0->1 (macro on); glitch_clr -> 0.
- REQ-031: smask[5]=1, din[5] falls between strobes -> no change until the next strobe loads it, then dout[5]=0 two edges later.
- REQ-032: din=6'h00 at once -> all dout bits fall on the same edge k+2; rst pulse at k+1 -> dout=6'h3F, busy=0, no later transition.
